// File: rtl/axi_up_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_up_pkg
// Description : Shared definitions for the user-plugin AXI burst planner.
//               Holds the 4 KB page size, the planner state encoding and
//               helpers that derive beat bytes / AxSIZE from the data width.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_up_pkg;

  localparam int PAGE_BYTES = 4096;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // Bytes transferred per AXI beat.
  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

  // AxSIZE encoding: log2 of the beat byte count.
  function automatic logic [2:0] axsize(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_up_burst_split_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_up_burst_split_if
// Description : Command and burst-descriptor handshake bundle of the burst
//               planner.
//               slave  : the planner (accepts commands, emits descriptors)
//               master : the surrounding logic (issues commands, consumes
//                        descriptors)
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_up_burst_split_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int REG_SIZE_WIDTH = 15
);

  // Command side
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i;
  logic [REG_SIZE_WIDTH-1:0] cmd_size_i;

  // Burst descriptor side
  logic                      burst_valid_o;
  logic                      burst_ready_i;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr_o;
  logic [7:0]                burst_len_o;
  logic [2:0]                burst_size_o;
  logic                      burst_last_o;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_size_i, burst_ready_i,
    output cmd_ready_o, burst_valid_o, burst_addr_o, burst_len_o,
           burst_size_o, burst_last_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_size_i, burst_ready_i,
    input  cmd_ready_o, burst_valid_o, burst_addr_o, burst_len_o,
           burst_size_o, burst_last_o
  );

endinterface
`default_nettype wire

// File: rtl/axi_up_chunk_calc.sv
`default_nettype none
// ============================================================================
// Module      : axi_up_chunk_calc
// Description : Combinational size of the next burst: the smallest of the
//               bytes still to move, the beat-cap in bytes and the distance
//               to the next 4 KB boundary.
// Ports       : page_off_i   - current address bits [11:0]
//               remaining_i  - bytes still to move
//               chunk_o      - bytes covered by this burst
//               len_o        - AxLEN (beats - 1)
//               last_o       - this burst finishes the command
// Revision    : 1.0 - initial release
// ============================================================================
module axi_up_chunk_calc
  import axi_up_pkg::*;
#(
  parameter int REG_SIZE_WIDTH = 15,
  parameter int BEAT_BYTES     = 8,
  parameter int MAX_BEATS      = 256
) (
  input  wire logic [11:0]               page_off_i,
  input  wire logic [REG_SIZE_WIDTH-1:0] remaining_i,
  output logic      [REG_SIZE_WIDTH-1:0] chunk_o,
  output logic      [7:0]                len_o,
  output logic                           last_o
);

  localparam int CAP_BYTES = MAX_BEATS * BEAT_BYTES;
  localparam int LOG2_BB   = $clog2(BEAT_BYTES);
  // Wide enough for the page distance (13 bits), the byte count and the cap,
  // so no operand is truncated before the comparisons.
  localparam int CAP_W     = $clog2(CAP_BYTES + 1);
  localparam int BASE_W    = (REG_SIZE_WIDTH > 13) ? REG_SIZE_WIDTH : 13;
  localparam int CALC_W    = (BASE_W > CAP_W) ? BASE_W : CAP_W;

  logic [CALC_W-1:0] w_rem;
  logic [CALC_W-1:0] w_cap;
  logic [CALC_W-1:0] w_to_page;
  logic [CALC_W-1:0] w_min;
  logic [CALC_W-1:0] w_beats;

  always_comb begin
    w_rem     = CALC_W'(remaining_i);
    w_cap     = CALC_W'(CAP_BYTES);
    w_to_page = CALC_W'(PAGE_BYTES) - CALC_W'(page_off_i);

    w_min = w_rem;
    if (w_cap < w_min) begin
      w_min = w_cap;
    end
    if (w_to_page < w_min) begin
      w_min = w_to_page;
    end

    w_beats = w_min >> LOG2_BB;
  end

  // chunk never exceeds remaining, so it always fits the byte-count width.
  assign chunk_o = w_min[REG_SIZE_WIDTH-1:0];
  assign len_o   = 8'(w_beats - CALC_W'(1));
  assign last_o  = (w_min == w_rem);

endmodule
`default_nettype wire

// File: rtl/axi_up_burst_split.sv
`default_nettype none
// ============================================================================
// Module      : axi_up_burst_split
// Description : Splits a copy command (start address, byte count) into AXI4
//               INCR burst descriptors that never cross a 4 KB page and never
//               exceed MAX_BEATS beats.
// Ports       : ACLK, ARESETn - clock, asynchronous active-low reset
//               bus           - command / descriptor handshakes (slave side)
//               done_o        - one-cycle pulse, command complete
//               err_o         - one-cycle pulse, misaligned command rejected
//               busy_o        - high while descriptors are being issued
// Revision    : 1.0 - initial release
// ============================================================================
module axi_up_burst_split
  import axi_up_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int REG_SIZE_WIDTH = 15,
  parameter int MAX_BEATS      = 256
) (
  input  wire logic             ACLK,
  input  wire logic             ARESETn,
  axi_up_burst_split_if.slave   bus,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int BB = beat_bytes(AXI_DATA_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = AXI_ADDR_WIDTH'(BB - 1);
  localparam logic [REG_SIZE_WIDTH-1:0] SIZE_ALIGN_MASK = REG_SIZE_WIDTH'(BB - 1);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [REG_SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [REG_SIZE_WIDTH-1:0] w_chunk;
  logic [7:0]                w_len;
  logic                      w_last;
  logic                      w_split;

  axi_up_chunk_calc #(
    .REG_SIZE_WIDTH (REG_SIZE_WIDTH),
    .BEAT_BYTES     (BB),
    .MAX_BEATS      (MAX_BEATS)
  ) u_chunk_calc (
    .page_off_i  (cur_addr_q[11:0]),
    .remaining_i (remaining_q),
    .chunk_o     (w_chunk),
    .len_o       (w_len),
    .last_o      (w_last)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          if (((bus.cmd_addr_i & ADDR_ALIGN_MASK) != '0) ||
              ((bus.cmd_size_i & SIZE_ALIGN_MASK) != '0)) begin
            err_d = 1'b1;
          end else if (bus.cmd_size_i == '0) begin
            done_d = 1'b1;
          end else begin
            cur_addr_d  = bus.cmd_addr_i;
            remaining_d = bus.cmd_size_i;
            state_d     = SPLIT;
          end
        end
      end
      SPLIT: begin
        if (bus.burst_ready_i) begin
          // Address wraps naturally at the top of the address space.
          cur_addr_d  = cur_addr_q + AXI_ADDR_WIDTH'(w_chunk);
          remaining_d = remaining_q - w_chunk;
          if (w_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Descriptor fields are forced to zero outside SPLIT so the idle bus is
  // quiet regardless of the leftover address/count registers.
  assign w_split           = (state_q == SPLIT);
  assign bus.cmd_ready_o   = ~w_split;
  assign bus.burst_valid_o = w_split;
  assign bus.burst_addr_o  = w_split ? cur_addr_q : '0;
  assign bus.burst_len_o   = w_split ? w_len : 8'd0;
  assign bus.burst_last_o  = w_split & w_last;
  assign bus.burst_size_o  = axsize(AXI_DATA_WIDTH);
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign busy_o            = w_split;

endmodule
`default_nettype wire

// File: tb/tb_axi_up_burst_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_up_burst_split
// Description : Self-checking bench for axi_up_burst_split. Expected
//               descriptors come from a queue-based reference that applies
//               the page / beat-cap / remaining-bytes rules directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_up_burst_split;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = 15;
  localparam int MAXB = 256;
  localparam int BB   = DW / 8;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  logic done_o, err_o, busy_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_len[$];
  logic          exp_last[$];

  axi_up_burst_split_if #(.AXI_ADDR_WIDTH(AW), .REG_SIZE_WIDTH(SW)) bus ();

  axi_up_burst_split #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .REG_SIZE_WIDTH (SW),
    .MAX_BEATS      (MAXB)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .done_o  (done_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference: walk the byte range, cutting at page ends and the beat cap.
  task automatic model_split(input logic [AW-1:0] a, input int sz);
    longint cur;
    int     rem;
    int     to_page;
    int     chunk;
    exp_addr.delete();
    exp_len.delete();
    exp_last.delete();
    cur = longint'(a);
    rem = sz;
    while (rem > 0) begin
      to_page = 4096 - int'(cur % 4096);
      chunk   = rem;
      if (MAXB * BB < chunk) chunk = MAXB * BB;
      if (to_page < chunk) chunk = to_page;
      exp_addr.push_back(cur[AW-1:0]);
      exp_len.push_back(8'(chunk / BB - 1));
      exp_last.push_back(chunk == rem);
      cur = (cur + longint'(chunk)) % (longint'(1) << AW);
      rem = rem - chunk;
    end
  endtask

  // Presents a command once the planner is ready; returns one cycle after
  // acceptance with the command inputs released.
  task automatic issue_cmd(input logic [AW-1:0] a, input logic [SW-1:0] s);
    int w;
    w = 0;
    while (bus.cmd_ready_o !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_total++;
    if (bus.cmd_ready_o !== 1'b1)
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1 within 50 cycles", bus.cmd_ready_o);
    else
      n_pass++;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = a;
    bus.cmd_size_i  = s;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_size_i  = '0;
  endtask

  // Runs one valid command and checks every descriptor, optional stalls,
  // and the completion cycle.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input int stall_idx, input int stall_n, input bit rnd_stall);
    int stalls;
    model_split(a, int'(s));
    issue_cmd(a, s);
    for (int i = 0; i < exp_addr.size(); i++) begin
      stalls = (i == stall_idx) ? stall_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k <= stalls; k++) begin
        n_total++;
        if (bus.burst_valid_o !== 1'b1 || bus.burst_addr_o !== exp_addr[i] ||
            bus.burst_len_o !== exp_len[i] || bus.burst_last_o !== exp_last[i] ||
            bus.burst_size_o !== 3'd3 || bus.cmd_ready_o !== 1'b0 ||
            done_o !== 1'b0 || busy_o !== 1'b1)
          $display("FAIL desc[%0d] cmd=%h/%h: got v=%b a=%h l=%0d last=%b sz=%0d rdy=%b done=%b busy=%b required v=1 a=%h l=%0d last=%b sz=3 rdy=0 done=0 busy=1",
                   i, a, s, bus.burst_valid_o, bus.burst_addr_o, bus.burst_len_o,
                   bus.burst_last_o, bus.burst_size_o, bus.cmd_ready_o, done_o, busy_o,
                   exp_addr[i], exp_len[i], exp_last[i]);
        else
          n_pass++;
        bus.burst_ready_i = (k == stalls);
        tick();
      end
      bus.burst_ready_i = 1'b0;
    end
    n_total++;
    if (done_o !== 1'b1 || bus.cmd_ready_o !== 1'b1 || bus.burst_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL completion cmd=%h/%h: got done=%b rdy=%b v=%b busy=%b required done=1 rdy=1 v=0 busy=0",
               a, s, done_o, bus.cmd_ready_o, bus.burst_valid_o, busy_o);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (2) tick();
    n_total++;
    if (bus.cmd_ready_o !== 1'b1 || bus.burst_valid_o !== 1'b0 || bus.burst_addr_o !== '0 ||
        bus.burst_len_o !== 8'd0 || bus.burst_last_o !== 1'b0 || bus.burst_size_o !== 3'd3 ||
        done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL reset_values: got rdy=%b v=%b a=%h l=%0d last=%b sz=%0d done=%b err=%b busy=%b required 1 0 0 0 0 3 0 0 0",
               bus.cmd_ready_o, bus.burst_valid_o, bus.burst_addr_o, bus.burst_len_o,
               bus.burst_last_o, bus.burst_size_o, done_o, err_o, busy_o);
    else
      n_pass++;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    run_cmd(32'h0000_1000, 15'h0040, -1, 0, 1'b0);
  endtask

  task automatic test_page_cross();
    run_cmd(32'h0000_0FF0, 15'h0020, -1, 0, 1'b0);
    // Wrap at the top of the address space.
    run_cmd(32'hFFFF_FFF0, 15'h0020, -1, 0, 1'b0);
  endtask

  task automatic test_max_beats();
    run_cmd(32'h0000_2000, 15'h1800, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cmd(32'h0000_2000, 15'h1800, 1, 5, 1'b0);
  endtask

  task automatic test_reject_empty();
    issue_cmd(32'h0000_3000, 15'h0000);
    n_total++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || bus.burst_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1)
      $display("FAIL empty_cmd: got done=%b err=%b v=%b rdy=%b required 1 0 0 1",
               done_o, err_o, bus.burst_valid_o, bus.cmd_ready_o);
    else
      n_pass++;
    tick();
    n_total++;
    if (done_o !== 1'b0 || bus.burst_valid_o !== 1'b0)
      $display("FAIL empty_pulse_width: got done=%b v=%b required 0 0", done_o, bus.burst_valid_o);
    else
      n_pass++;

    issue_cmd(32'h0000_1004, 15'h0010);
    n_total++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || bus.burst_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1)
      $display("FAIL misaligned_addr: got err=%b done=%b v=%b rdy=%b required 1 0 0 1",
               err_o, done_o, bus.burst_valid_o, bus.cmd_ready_o);
    else
      n_pass++;
    tick();
    n_total++;
    if (err_o !== 1'b0 || bus.burst_valid_o !== 1'b0)
      $display("FAIL err_pulse_width: got err=%b v=%b required 0 0", err_o, bus.burst_valid_o);
    else
      n_pass++;

    issue_cmd(32'h0000_1000, 15'h000C);
    n_total++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || bus.burst_valid_o !== 1'b0)
      $display("FAIL misaligned_size: got err=%b done=%b v=%b required 1 0 0",
               err_o, done_o, bus.burst_valid_o);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid();
    issue_cmd(32'h0000_2000, 15'h1800);
    bus.burst_ready_i = 1'b1;
    tick();
    bus.burst_ready_i = 1'b0;
    n_total++;
    if (bus.burst_valid_o !== 1'b1 || bus.burst_addr_o !== 32'h0000_2800)
      $display("FAIL reset_mid_second: got v=%b a=%h required v=1 a=00002800",
               bus.burst_valid_o, bus.burst_addr_o);
    else
      n_pass++;
    ARESETn = 1'b0;
    #1;
    n_total++;
    if (bus.burst_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.burst_addr_o !== '0 ||
        bus.burst_len_o !== 8'd0 || bus.burst_last_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL reset_mid_async: got v=%b rdy=%b a=%h l=%0d last=%b done=%b busy=%b required 0 1 0 0 0 0 0",
               bus.burst_valid_o, bus.cmd_ready_o, bus.burst_addr_o, bus.burst_len_o,
               bus.burst_last_o, done_o, busy_o);
    else
      n_pass++;
    tick();
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if (done_o !== 1'b0 || bus.burst_valid_o !== 1'b0)
        $display("FAIL reset_mid_quiet[%0d]: got done=%b v=%b required 0 0", c, done_o, bus.burst_valid_o);
      else
        n_pass++;
    end
    run_cmd(32'h0000_0000, 15'h0008, -1, 0, 1'b0);
  endtask

  // Back-to-back random commands with random backpressure; a new command is
  // issued in the completion cycle of the previous one.
  task automatic test_random();
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    int            kind;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 7));
      s    = SW'($urandom_range(1, 4095) * BB);
      case (kind)
        0: a = ($urandom & 32'hFFFF_F000) | (32'd4096 - 32'(BB * $urandom_range(1, 8)));
        1: a = 32'hFFFF_F000 | ($urandom & 32'h0000_0FF8);
        default: a = $urandom & ~32'(BB - 1);
      endcase
      if (kind == 7) begin
        a = a | 32'(1 + $urandom_range(0, BB - 2));
        issue_cmd(a, s);
        n_total++;
        if (err_o !== 1'b1 || done_o !== 1'b0 || bus.burst_valid_o !== 1'b0)
          $display("FAIL rand_reject[%0d] a=%h: got err=%b done=%b v=%b required 1 0 0",
                   n, a, err_o, done_o, bus.burst_valid_o);
        else
          n_pass++;
      end else begin
        run_cmd(a, s, -1, 0, 1'b1);
      end
    end
    tick();
  endtask

  initial begin
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_addr_i    = '0;
    bus.cmd_size_i    = '0;
    bus.burst_ready_i = 1'b0;
    test_reset();
    test_single();
    test_page_cross();
    test_max_beats();
    test_backpressure();
    test_reject_empty();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_up_burst_split.md
# axi_up_burst_split

Burst planner for the user-plugin copy engine. Sits directly downstream of the plugin's command/control logic and upstream of the AXI master channel drivers. Takes one copy command (start address, byte count) and emits a sequence of AXI4 INCR burst descriptors, one per handshake. Each descriptor honours the 4 KB page rule and a maximum beat count, so the channel drivers never have to split bursts themselves.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 64, data width; beat bytes BB = AXI_DATA_WIDTH/8
- REG_SIZE_WIDTH, 15, byte-count width (at most 32 KB)
- MAX_BEATS, 256, per-burst beat cap; power of two, 1..256

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - ACLK  in  1  clock
  - ARESETn  in  1  asynchronous active-low reset
- Command side:
  - cmd_valid_i  in  1  command request
  - cmd_ready_o  out  1  command accepted when both valid and ready are high
  - cmd_addr_i  in  AXI_ADDR_WIDTH  start byte address
  - cmd_size_i  in  REG_SIZE_WIDTH  byte count
- Burst side:
  - burst_valid_o  out  1  descriptor valid
  - burst_ready_i  in  1  descriptor consumed
  - burst_addr_o  out  AXI_ADDR_WIDTH  burst start address
  - burst_len_o  out  8  AXI AxLEN, equal to beats-1
  - burst_size_o  out  3  AXI AxSIZE = log2(BB), constant
  - burst_last_o  out  1  final descriptor of the command
- Status:
  - done_o  out  1  one-cycle pulse, command complete
  - err_o  out  1  one-cycle pulse, command rejected
  - busy_o  out  1  high while in SPLIT

## Operation
- States:
  - IDLE: cmd_ready_o=1, burst_valid_o=0.
  - SPLIT: cmd_ready_o=0, burst_valid_o=1.
- Registers: cur_addr (AXI_ADDR_WIDTH bits), remaining (REG_SIZE_WIDTH bits).
- Command accept in IDLE:
  - If cmd_addr_i or cmd_size_i is not BB-aligned: err_o pulses next cycle; stay in IDLE; no descriptors.
  - Else if cmd_size_i==0: done_o pulses next cycle; stay in IDLE.
  - Else: load cur_addr and remaining; go to SPLIT.
- Chunk calculation in SPLIT (combinational from registers):
  - to_page = 4096 - cur_addr[11:0], 13 bits.
  - cap = MAX_BEATS*BB.
  - chunk = min(remaining, cap, to_page).
- Descriptor outputs:
  - burst_addr_o = cur_addr.
  - burst_len_o = chunk/BB - 1.
  - burst_last_o = (chunk == remaining).
- On burst handshake:
  - cur_addr += chunk, modulo 2^AXI_ADDR_WIDTH.
  - remaining -= chunk.
  - If burst_last_o: go to IDLE and pulse done_o.
- Width rules:
  - Compare chunk widths with no truncation; extend operands to max(REG_SIZE_WIDTH, 13) bits.
  - remaining never underflows, because chunk ≤ remaining.

## Timing
- Reset values: cmd_ready_o=1 (IDLE); burst_valid_o=0; burst_addr_o=0; burst_len_o=0; burst_last_o=0; done_o=0; err_o=0; busy_o=0. burst_size_o is constant.
- Command accepted in cycle T → first descriptor valid at T+1, or done_o/err_o at T+1.
- Throughput: one descriptor per cycle while burst_ready_i is held high.
- Backpressure: while burst_valid_o && !burst_ready_i, all burst_* outputs stay stable.
- Completion: last handshake in cycle L → done_o=1 and cmd_ready_o=1 in cycle L+1. A new command may be accepted in L+1.
- Command acceptance is impossible in SPLIT, because cmd_ready_o=0.
- Reset mid-operation: outputs return to reset values immediately. No done_o is generated. The in-flight command is dropped.
- Page end: a chunk ending exactly on a 4 KB page makes the next cur_addr page-aligned. Wrap at the top of the address space is legal.

## Structure
- Shared package axi_up_pkg holds:
  - PAGE_BYTES=4096
  - the state enum {IDLE, SPLIT}
  - function beat_bytes(AXI_DATA_WIDTH)
  - function axsize(AXI_DATA_WIDTH)
- One combinational sub-module, axi_up_chunk_calc (cur_addr, remaining → chunk, len, last), is natural. The FSM and registers stay in the top level.

## Test plan
- addr 0x1000, size 0x40 → one descriptor: addr 0x1000, len 7, size 3, last=1; done_o one cycle after the handshake.
- addr 0x0FF0, size 0x20 → two descriptors:
  - addr 0x0FF0, len 1, last=0
  - addr 0x1000, len 1, last=1
- addr 0x2000, size 0x1800, MAX_BEATS=256 → three descriptors, len 255 each:
  - addr 0x2000
  - addr 0x2800
  - addr 0x3000, last=1
- Same command as the previous case, with burst_ready_i low for 5 cycles on the second descriptor → addr 0x2800 and len 255 held stable; cmd_ready_o=0 throughout; no done_o early.
- Command rejection and empty command:
  - size 0 → done_o only, no burst_valid_o.
  - addr 0x1004, size 0x10 → err_o only.
  - In both cases cmd_ready_o stays 1.
- ARESETn low during the second descriptor of a 3-burst command → burst_valid_o=0 immediately and no done_o. A following addr 0x0, size 0x8 command yields a single descriptor with len 0.
